// File: rtl/upd7800_pkg.sv
// Shared types and opcode constants for the reduced uPD7800 core.
// Imported by the bus sequencer, the CPU top and the bench.
package upd7800_pkg;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} tstate_t;
  typedef enum logic [1:0] {FETCH, OPER, WRITE} cycle_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_MVI_A  = 8'h69;
  localparam logic [7:0] OP_JMP    = 8'h54;
  localparam logic [7:0] OP_PFX70  = 8'h70;
  localparam logic [7:0] OP_MOV_WA = 8'h79;

  // phase: index of the most recent strobe (0=CP1 rise .. 3=CP2 fall)
  typedef struct packed {
    tstate_t    tstate;
    cycle_t     cycle;
    logic       cp2;
    logic [1:0] phase;
  } dbg_t;

  function automatic logic has_operand(input logic [7:0] op);
    return (op == OP_MVI_A) || (op == OP_JMP) || (op == OP_PFX70);
  endfunction

endpackage

// File: rtl/upd7800_if.sv
// Memory-side bus of the uPD7800 core: address, split data bus, drive enable, M1.
// Handshake: none; the CPU owns timing, memory must present db_i for the current a by CP2 fall of T3.
interface upd7800_if;
  logic [15:0] a;
  logic [7:0]  db_i;
  logic [7:0]  db_o;
  logic        db_oe;
  logic        m1;

  modport master (output a, output db_o, output db_oe, output m1, input db_i);
  modport slave  (input a, input db_o, input db_oe, input m1, output db_i);
endinterface

// File: rtl/upd7800_busseq.sv
// Bus sequencer: T-state counter, cp2 level, and registered drive of A, DB_O, DB_OE, M1.
// The cycle kind/address/data presented by the top are taken at T1 entry.
module upd7800_busseq
  import upd7800_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            cp1_posedge,
  input  logic            cp1_negedge,
  input  logic            cp2_posedge,
  input  logic            cp2_negedge,
  input  cycle_t          cyc,
  input  logic [15:0]     cyc_addr,
  input  logic [7:0]      wdata,
  upd7800_if.master       bus,
  output tstate_t         tstate,
  output logic            cp2,
  output logic [1:0]      phase,
  output logic            t3_done
);

  tstate_t state, state_n;
  logic    enter_t1, enter_t2;

  always_comb begin
    state_n = state;
    if (cp1_posedge) begin
      case (state)
        IDLE:    state_n = T1;
        T1:      state_n = T2;
        T2:      state_n = T3;
        T3:      state_n = T1;
        default: state_n = IDLE;
      endcase
    end
  end

  assign enter_t1 = cp1_posedge && ((state == IDLE) || (state == T3));
  assign enter_t2 = cp1_posedge && (state == T1);
  // Last strobe of T3: read data sample and instruction-state update point
  assign t3_done  = cp2_negedge && (state == T3);
  assign tstate   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cp2       <= 1'b0;
      phase     <= 2'd0;
      bus.a     <= 16'h0000;
      bus.db_o  <= 8'h00;
      bus.db_oe <= 1'b0;
      bus.m1    <= 1'b0;
    end else begin
      state <= state_n;
      if (cp2_posedge) cp2 <= 1'b1;
      if (cp2_negedge) cp2 <= 1'b0;
      if (cp1_posedge) phase <= 2'd0;
      if (cp1_negedge) phase <= 2'd1;
      if (cp2_posedge) phase <= 2'd2;
      if (cp2_negedge) phase <= 2'd3;
      if (enter_t1) begin
        bus.a     <= cyc_addr;
        bus.m1    <= (cyc == FETCH);
        bus.db_oe <= 1'b0;
        if (cyc == WRITE) bus.db_o <= wdata;
      end
      if (enter_t2) bus.db_oe <= (cyc == WRITE);
    end
  end

endmodule

// File: rtl/upd7800_cpu.sv
// Reduced uPD7800 core: PC, accumulator and decode of NOP / MVI A / JMP / MOV (word),A.
// Every bus cycle is T1-T3; decode advances once per cycle at the T3 read-sample strobe.
module upd7800_cpu
  import upd7800_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
)(
  input  logic      clk,
  input  logic      reset,
  input  logic      cp1_posedge,
  input  logic      cp1_negedge,
  input  logic      cp2_posedge,
  input  logic      cp2_negedge,
  upd7800_if.master bus,
  output dbg_t      dbg
);

  logic [15:0] pc;
  logic [7:0]  acc;
  cycle_t      kind;
  logic [7:0]  op;
  logic [1:0]  step;
  logic [7:0]  lo;
  logic [15:0] wr_addr;

  tstate_t     tstate;
  logic        cp2;
  logic [1:0]  phase;
  logic        t3_done;
  logic [15:0] cyc_addr;

  assign cyc_addr = (kind == WRITE) ? wr_addr : pc;

  upd7800_busseq u_busseq (
    .clk         (clk),
    .reset       (reset),
    .cp1_posedge (cp1_posedge),
    .cp1_negedge (cp1_negedge),
    .cp2_posedge (cp2_posedge),
    .cp2_negedge (cp2_negedge),
    .cyc         (kind),
    .cyc_addr    (cyc_addr),
    .wdata       (acc),
    .bus         (bus),
    .tstate      (tstate),
    .cp2         (cp2),
    .phase       (phase),
    .t3_done     (t3_done)
  );

  assign dbg.tstate = tstate;
  assign dbg.cycle  = kind;
  assign dbg.cp2    = cp2;
  assign dbg.phase  = phase;

  // kind is the type of the cycle in progress; it changes at t3_done to the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      acc     <= 8'h00;
      kind    <= FETCH;
      op      <= OP_NOP;
      step    <= 2'd0;
      lo      <= 8'h00;
      wr_addr <= 16'h0000;
    end else if (t3_done) begin
      case (kind)
        FETCH: begin
          pc   <= pc + 16'd1;
          op   <= bus.db_i;
          step <= 2'd0;
          kind <= has_operand(bus.db_i) ? OPER : FETCH;
        end
        OPER: begin
          pc   <= pc + 16'd1;
          step <= step + 2'd1;
          case (op)
            OP_MVI_A: begin
              acc  <= bus.db_i;
              kind <= FETCH;
            end
            OP_JMP: begin
              if (step == 2'd0) begin
                lo <= bus.db_i;
              end else begin
                pc   <= {bus.db_i, lo};
                kind <= FETCH;
              end
            end
            OP_PFX70: begin
              // A 70 prefix not followed by 79 retires as a two-byte NOP
              if (step == 2'd0) begin
                if (bus.db_i != OP_MOV_WA) kind <= FETCH;
              end else if (step == 2'd1) begin
                lo <= bus.db_i;
              end else begin
                wr_addr <= {bus.db_i, lo};
                kind    <= WRITE;
              end
            end
            default: kind <= FETCH;
          endcase
        end
        default: kind <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_upd7800_cpu.sv
// Bench for upd7800_cpu: directed programs, expected bus cycles queued per test,
// monitor pops one entry at every T1 and checks address, M1, write data, DB_OE window and spacing.
module tb_upd7800_cpu;
  import upd7800_pkg::*;

  localparam int W = 26; // {a[15:0], m1, wr, dbo[7:0]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cp1_posedge = 1'b0, cp1_negedge = 1'b0, cp2_posedge = 1'b0, cp2_negedge = 1'b0;
  dbg_t dbg;
  logic [7:0] mem [0:65535];

  upd7800_if bus ();
  assign bus.db_i = mem[bus.a];

  upd7800_cpu #(.RESET_VECTOR(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .cp1_posedge (cp1_posedge),
    .cp1_negedge (cp1_negedge),
    .cp2_posedge (cp2_posedge),
    .cp2_negedge (cp2_negedge),
    .bus         (bus),
    .dbg         (dbg)
  );

  // clock / strobe block
  always #125 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      cp1_posedge = (ph == 0);
      cp1_negedge = (ph == 1);
      cp2_posedge = (ph == 2);
      cp2_negedge = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [15:0] a);
    exp_q.push_back({a, 1'b1, 1'b0, 8'h00});
  endtask

  task automatic push_oper(input logic [15:0] a);
    exp_q.push_back({a, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic push_write(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, 1'b0, 1'b1, d});
  endtask

  // monitor
  initial begin
    logic rst_s, p2p, p2n, exp_cp2, cur_wr, cur_m1, have_prev;
    logic [15:0] cur_a;
    logic [W-1:0] e;
    tstate_t prev_ts, ts;
    int clk_cnt, last_t1;
    clk_cnt = 0; last_t1 = 0; have_prev = 1'b0; exp_cp2 = 1'b0;
    cur_wr = 1'b0; cur_m1 = 1'b0; cur_a = 16'h0000; prev_ts = IDLE;
    forever begin
      @(posedge clk);
      clk_cnt++;
      rst_s = reset; p2p = cp2_posedge; p2n = cp2_negedge;
      #10;
      if (rst_s) begin
        have_prev = 1'b0; exp_cp2 = 1'b0; cur_wr = 1'b0; prev_ts = IDLE;
      end else begin
        if (p2p) exp_cp2 = 1'b1;
        else if (p2n) exp_cp2 = 1'b0;
        check("cp2_level", 32'(dbg.cp2), 32'(exp_cp2));
        ts = dbg.tstate;
        if (ts == T1 && prev_ts != T1) begin
          if (have_prev) check("t1_spacing", clk_cnt - last_t1, 12);
          last_t1 = clk_cnt;
          have_prev = 1'b1;
          if (exp_q.size() == 0) begin
            vectors++; errs++;
            $display("FAIL unexpected_cycle: got a=%h m1=%b expected none", bus.a, bus.m1);
            cur_wr = 1'b0; cur_a = bus.a; cur_m1 = bus.m1;
          end else begin
            e = exp_q.pop_front();
            cur_a = e[25:10]; cur_m1 = e[9]; cur_wr = e[8];
            check("t1_addr", 32'(bus.a), 32'(cur_a));
            check("t1_m1", 32'(bus.m1), 32'(cur_m1));
            if (cur_wr) check("write_data", 32'(bus.db_o), 32'(e[7:0]));
          end
        end else if (ts == T2 || ts == T3) begin
          check("addr_hold", 32'(bus.a), 32'(cur_a));
          check("m1_hold", 32'(bus.m1), 32'(cur_m1));
        end
        check("db_oe", 32'(bus.db_oe), 32'(cur_wr && (ts == T2 || ts == T3)));
        prev_ts = ts;
      end
    end
  end

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_for(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_clk);
    for (int i = 0; i < max_clk; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      vectors++; errs++;
      $display("FAIL %s_timeout: got %0d cycles outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // reset state, then a NOP sweep
    clear_mem();
    reset_for(44);
    check("rst_addr", 32'(bus.a), 32'h0000);
    check("rst_db_oe", 32'(bus.db_oe), 32'h0);
    check("rst_m1", 32'(bus.m1), 32'h0);
    check("rst_db_o", 32'(bus.db_o), 32'h00);
    check("rst_state", 32'(dbg.tstate), 32'(IDLE));
    for (int i = 0; i < 6; i++) push_fetch(16'(i));
    release_reset();
    wait_drain("nop_sweep", 200);

    // JMP 8000
    reset_for(4);
    clear_mem();
    mem[16'h0000] = 8'h54; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h80;
    push_fetch(16'h0000); push_oper(16'h0001); push_oper(16'h0002);
    push_fetch(16'h8000); push_fetch(16'h8001);
    release_reset();
    wait_drain("jmp", 200);

    // MVI A,A5 ; MOV (1234),A
    reset_for(4);
    clear_mem();
    mem[0] = 8'h69; mem[1] = 8'hA5; mem[2] = 8'h70; mem[3] = 8'h79; mem[4] = 8'h34; mem[5] = 8'h12;
    push_fetch(16'h0000); push_oper(16'h0001); push_fetch(16'h0002);
    push_oper(16'h0003); push_oper(16'h0004); push_oper(16'h0005);
    push_write(16'h1234, 8'hA5); push_fetch(16'h0006);
    release_reset();
    wait_drain("mov_write", 300);

    // same program, reset during write T2; then store acc to prove it cleared
    reset_for(4);
    push_fetch(16'h0000); push_oper(16'h0001); push_fetch(16'h0002);
    push_oper(16'h0003); push_oper(16'h0004); push_oper(16'h0005);
    push_write(16'h1234, 8'hA5);
    release_reset();
    wait_drain("pre_abort", 300);
    for (int i = 0; i < 16; i++) begin
      if (bus.db_oe) break;
      @(negedge clk);
    end
    check("abort_db_oe_high", 32'(bus.db_oe), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_db_oe_drop", 32'(bus.db_oe), 32'h0);
    check("abort_addr", 32'(bus.a), 32'h0000);
    check("abort_m1", 32'(bus.m1), 32'h0);
    reset_for(4);
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h79; mem[2] = 8'h10; mem[3] = 8'h20;
    push_fetch(16'h0000); push_oper(16'h0001); push_oper(16'h0002); push_oper(16'h0003);
    push_write(16'h2010, 8'h00); push_fetch(16'h0004);
    release_reset();
    wait_drain("post_abort", 300);

    // 70 12 pair as NOP, then JMP FFFF and PC wrap
    reset_for(4);
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h12; mem[2] = 8'h54; mem[3] = 8'hFF; mem[4] = 8'hFF;
    push_fetch(16'h0000); push_oper(16'h0001); push_fetch(16'h0002);
    push_oper(16'h0003); push_oper(16'h0004); push_fetch(16'hFFFF); push_fetch(16'h0000);
    release_reset();
    wait_drain("wrap", 300);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
